// File: rtl/pipe_hazard_ctrl_if.sv
// Purpose: hazard-controller bundle; ID/EXE/MEM hazard inputs in, pipeline enables and debug status out.
// Latency: wires only; enables respond combinationally to the hazard inputs.
// Backpressure: mem_wait freezes the pipeline; no other flow control.
// Ports: master = pipeline side (drives register numbers/flags, sees enables);
//        slave  = pipe_hazard_ctrl (sees hazard inputs, drives enables, selects, state, counters).
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [4:0]       ex_destR;
  logic             ewreg;
  logic             em2reg;
  logic [4:0]       m_destR;
  logic             mwreg;
  logic             mm2reg;
  logic             e_branch;
  logic             e_taken;
  logic             mem_wait;

  logic             pc_we;
  logic             pc_sel_br;
  logic             if_id_we;
  logic             if_id_flush;
  logic             id_exe_we;
  logic             id_exe_bubble;
  logic [1:0]       fwda;
  logic [1:0]       fwdb;
  logic [1:0]       ctrl_state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] hold_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, ex_destR, ewreg, em2reg,
           m_destR, mwreg, mm2reg, e_branch, e_taken, mem_wait,
    input  pc_we, pc_sel_br, if_id_we, if_id_flush, id_exe_we, id_exe_bubble,
           fwda, fwdb, ctrl_state, stall_cnt, flush_cnt, hold_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, ex_destR, ewreg, em2reg,
           m_destR, mwreg, mm2reg, e_branch, e_taken, mem_wait,
    output pc_we, pc_sel_br, if_id_we, if_id_flush, id_exe_we, id_exe_bubble,
           fwda, fwdb, ctrl_state, stall_cnt, flush_cnt, hold_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Purpose: 5-stage pipeline hazard control: load-use stall, taken-branch flush, memory hold, ID forwarding selects.
// Latency: enables and forwarding selects are combinational (0 cycles); ctrl_state and counters update on the next edge.
// Backpressure: mem_wait forces HOLD (all enables low) and outranks any pending flush or stall.
// Ports: clk, rst (async active-high); hz = pipe_hazard_ctrl_if.slave carrying all hazard inputs and control outputs.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  logic             load_use;
  logic             br_taken;

  // EXE ALU result beats MEM; a load still in EXE has no data yet, so it never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rn,
    input logic [4:0] ex_d, input logic ew, input logic em,
    input logic [4:0] m_d,  input logic mw, input logic mm
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (ew && !em && ex_d != 5'd0 && ex_d == rn)
      sel = 2'b01;
    else if (mw && !mm && m_d != 5'd0 && m_d == rn)
      sel = 2'b10;
    else if (mw && mm && m_d != 5'd0 && m_d == rn)
      sel = 2'b11;
    return sel;
  endfunction

  always_comb begin
    load_use = hz.ewreg && hz.em2reg && (hz.ex_destR != 5'd0) &&
               ((hz.id_use_rs && hz.ex_destR == hz.id_rs) ||
                (hz.id_use_rt && hz.ex_destR == hz.id_rt));
    br_taken = hz.e_branch && hz.e_taken;

    // Action priority HOLD > FLUSH > STALL > RUN; the chosen action is also the next state.
    if (hz.mem_wait)      state_d = ST_HOLD;
    else if (br_taken)    state_d = ST_FLUSH;
    else if (load_use)    state_d = ST_STALL;
    else                  state_d = ST_RUN;

    hz.pc_we         = 1'b1;
    hz.pc_sel_br     = 1'b0;
    hz.if_id_we      = 1'b1;
    hz.if_id_flush   = 1'b0;
    hz.id_exe_we     = 1'b1;
    hz.id_exe_bubble = 1'b0;

    case (state_d)
      ST_HOLD: begin
        hz.pc_we     = 1'b0;
        hz.if_id_we  = 1'b0;
        hz.id_exe_we = 1'b0;
      end
      ST_FLUSH: begin
        hz.pc_sel_br     = 1'b1;
        hz.if_id_flush   = 1'b1;
        hz.id_exe_bubble = 1'b1;
      end
      ST_STALL: begin
        hz.pc_we         = 1'b0;
        hz.if_id_we      = 1'b0;
        hz.id_exe_bubble = 1'b1;
      end
      default: ;
    endcase

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    if (state_d == ST_STALL && stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + 1'b1;
    if (state_d == ST_FLUSH && flush_cnt_q != {CNT_W{1'b1}}) flush_cnt_d = flush_cnt_q + 1'b1;
    if (state_d == ST_HOLD  && hold_cnt_q  != {CNT_W{1'b1}}) hold_cnt_d  = hold_cnt_q + 1'b1;

    hz.fwda = fwd_sel(hz.id_rs, hz.ex_destR, hz.ewreg, hz.em2reg, hz.m_destR, hz.mwreg, hz.mm2reg);
    hz.fwdb = fwd_sel(hz.id_rt, hz.ex_destR, hz.ewreg, hz.em2reg, hz.m_destR, hz.mwreg, hz.mm2reg);

    hz.ctrl_state = state_q;
    hz.stall_cnt  = stall_cnt_q;
    hz.flush_cnt  = flush_cnt_q;
    hz.hold_cnt   = hold_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage MIPS pipeline. It sits beside the ID stage and drives the PC, IF/ID and ID/EXE pipeline registers. It detects load-use hazards and stalls, flushes wrong-path instructions on a taken branch resolved in EXE, and freezes the pipeline while memory is busy. It also produces the ID-stage forwarding selects that travel into ID/EXE, and keeps saturating event counters for performance debug.

## Interface
- CNT_W, 16, width of each event counter
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- id_rs, id_rt  in  5 each  source register numbers of the instruction in ID
- id_use_rs, id_use_rt  in  1 each  instruction in ID reads rs / rt
- ex_destR  in  5  destination register of the instruction in EXE
- ewreg, em2reg  in  1 each  EXE instruction writes the register file / is a load
- m_destR  in  5  destination register of the instruction in MEM
- mwreg, mm2reg  in  1 each  MEM instruction writes the register file / is a load
- e_branch, e_taken  in  1 each  EXE holds a branch / branch condition true
- mem_wait  in  1  data or instruction memory not ready this cycle
- pc_we  out  1  PC load enable
- pc_sel_br  out  1  PC loads the branch target instead of PC+4
- if_id_we  out  1  IF/ID register load enable
- if_id_flush  out  1  IF/ID loads a NOP
- id_exe_we  out  1  ID/EXE register load enable
- id_exe_bubble  out  1  ID/EXE loads zeroed control (wreg, m2reg, wmem, branch = 0)
- fwda, fwdb  out  2 each  ID operand select: 00 regfile, 01 EXE ALU result, 10 MEM ALU result, 11 MEM load data
- ctrl_state  out  2  registered FSM state
- stall_cnt, flush_cnt, hold_cnt  out  CNT_W each  saturating event counters

## Operation
- Actions are mutually exclusive and evaluated combinationally each cycle, in priority order: HOLD > FLUSH > STALL > RUN.
- HOLD (mem_wait=1): all enables 0; bubble, flush and pc_sel_br are 0.
- FLUSH (e_branch & e_taken & !mem_wait):
  - pc_we=1, pc_sel_br=1.
  - if_id_we=1, if_id_flush=1.
  - id_exe_we=1, id_exe_bubble=1.
  - A simultaneous load-use condition is ignored, because the ID instruction is squashed.
- STALL (load-use, no flush or hold): load-use = ewreg & em2reg & ex_destR≠0 & ((id_use_rs & ex_destR==id_rs) | (id_use_rt & ex_destR==id_rt)).
  - pc_we=0, if_id_we=0.
  - id_exe_we=1, id_exe_bubble=1.
- RUN: all enables 1; bubble, flush and pc_sel_br are 0.
- Forwarding, computed per operand (shown for rs/fwda):
  - 01 if ewreg & !em2reg & ex_destR≠0 & ex_destR==id_rs.
  - Otherwise 10 if mwreg & !mm2reg & m_destR≠0 & m_destR==id_rs.
  - Otherwise 11 if mwreg & mm2reg & m_destR≠0 & m_destR==id_rs.
  - Otherwise 00.
  - EXE match beats MEM match. Register 0 never forwards.
  - The select depends only on register numbers and write flags, independent of id_use_*.
- FSM ctrl_state records the action of the previous cycle: 0 RUN, 1 STALL, 2 FLUSH, 3 HOLD. It updates every edge to the action evaluated this cycle.
- Counters: each increments by 1 at the edge closing a cycle whose action is STALL, FLUSH or HOLD respectively. Each saturates at 2^CNT_W−1 and does not wrap.

## Timing
- Reset (asynchronous, takes effect immediately):
  - ctrl_state=RUN; all counters 0.
  - Combinational outputs follow their inputs (RUN values when inputs are idle).
- All control outputs are combinational: zero-cycle latency from inputs.
- A load-use stall lasts exactly one cycle. After the bubble, the load is in MEM and fwd=11 resolves the hazard.
- A flush occupies one cycle. The branch target is fetched on the following cycle.
- mem_wait during a pending hazard: HOLD for its full duration. The hazard is re-evaluated the cycle mem_wait drops, and counts as STALL/FLUSH only then.
- Reset asserted mid-stall or mid-hold: state and counters clear at once. Post-reset behaviour depends only on the current inputs.

## Test plan
- lw $2 in EXE (ewreg=1, em2reg=1, ex_destR=2), ID add uses rs=2 → pc_we=0, if_id_we=0, id_exe_bubble=1. Next cycle, with the load in MEM (m_destR=2, mm2reg=1): fwda=11, ctrl_state=1, stall_cnt=1.
- EXE ALU op to $5 while MEM ALU op also targets $5, ID rt=5 → fwdb=01. With ex_destR=0 and m_destR=0, id_rs=id_rt=0 → fwda=fwdb=00.
- Taken branch in EXE together with a load-use condition in ID → pc_sel_br=1, if_id_flush=1, id_exe_bubble=1, pc_we=1. Next cycle ctrl_state=2; flush_cnt=1, stall_cnt unchanged.
- mem_wait held 3 cycles during a load-use condition → all enables 0 for 3 cycles, hold_cnt=3. The stall then occurs in cycle 4; stall_cnt=1.
- CNT_W=4, 20 consecutive HOLD cycles → hold_cnt stops at 15.
- rst pulsed asynchronously mid-HOLD (between clock edges) → ctrl_state=0 and counters 0 immediately, before the next edge.
